// File: rtl/fp_cmp_unit.sv
// Two-stage IEEE-754 binary32 comparator (FLE / FLT / FEQ) with valid/ready
// handshakes on both sides and a saturating invalid-operation counter.
// S1 holds operands, op and per-operand class bits; S2 holds result and nv.

// Per-operand classifier; one instance per operand.
module fp_cls (
  input  logic [31:0] x,
  output logic        zero,
  output logic        inf,
  output logic        qnan,
  output logic        snan,
  output logic        sign
);
  logic exp_max, man_nz;

  assign exp_max = &x[30:23];
  assign man_nz  = |x[22:0];
  assign zero    = ~|x[30:0];
  assign inf     = exp_max & ~man_nz;
  assign qnan    = exp_max & man_nz & x[22];
  assign snan    = exp_max & man_nz & ~x[22];
  assign sign    = x[31];
endmodule

module fp_cmp_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        result,
  output logic        nv,
  output logic [15:0] nv_count
);
  localparam logic [1:0] OP_FLE = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FEQ = 2'b10;

  // Index 0 is operand A, index 1 is operand B throughout.
  logic [1:0][31:0] opnd;
  logic [1:0]       c_zero, c_inf, c_qnan, c_snan, c_sign;

  logic [2:1]       vld_pipe;
  logic [31:0]      s1_a, s1_b;
  logic [1:0]       s1_op;
  logic [1:0]       s1_zero, s1_inf, s1_qnan, s1_snan, s1_sign;

  logic             s1_adv, s2_adv, accept;
  logic             any_nan, any_snan, both_zero, eq, lt;
  logic             cmp_res, cmp_nv;

  assign opnd = {fp_b, fp_a};

  fp_cls u_cls [1:0] (
    .x    (opnd),
    .zero (c_zero),
    .inf  (c_inf),
    .qnan (c_qnan),
    .snan (c_snan),
    .sign (c_sign)
  );

  // A stage moves when it is empty or its successor moves; S2 drains on out_ready.
  assign s2_adv    = ~vld_pipe[2] | out_ready;
  assign s1_adv    = ~vld_pipe[1] | s2_adv;
  assign in_ready  = rst_n & s1_adv;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_pipe[2];

  // Stage valid bits; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= accept;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // S1 payload: operands, op and class bits captured on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a    <= fp_a;
      s1_b    <= fp_b;
      s1_op   <= op;
      s1_zero <= c_zero;
      s1_inf  <= c_inf;
      s1_qnan <= c_qnan;
      s1_snan <= c_snan;
      s1_sign <= c_sign;
    end
  end

  // Compare S1 operands; NaNs force false, +0/-0 are equal.
  always_comb begin
    any_nan   = |(s1_qnan | s1_snan);
    any_snan  = |s1_snan;
    both_zero = &s1_zero;
    eq        = both_zero | (s1_a == s1_b);
    if (both_zero)                  lt = 1'b0;
    else if (s1_sign[0] != s1_sign[1]) lt = s1_sign[0];
    else if (&s1_inf)               lt = 1'b0;
    else if (s1_sign[0])            lt = s1_a[30:0] > s1_b[30:0];
    else                            lt = s1_a[30:0] < s1_b[30:0];

    cmp_res = 1'b0;
    cmp_nv  = 1'b0;
    case (s1_op)
      OP_FLE: begin cmp_res = ~any_nan & (lt | eq); cmp_nv = any_nan;  end
      OP_FLT: begin cmp_res = ~any_nan & lt;        cmp_nv = any_nan;  end
      OP_FEQ: begin cmp_res = ~any_nan & eq;        cmp_nv = any_snan; end
      default: ;
    endcase
  end

  // S2 result registers; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= 1'b0;
      nv     <= 1'b0;
    end else if (s2_adv && vld_pipe[1]) begin
      result <= cmp_res;
      nv     <= cmp_nv;
    end
  end

  // Count delivered results that raised nv, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n)                                        nv_count <= '0;
    else if (out_valid && out_ready && nv && ~&nv_count) nv_count <= nv_count + 16'd1;
  end
endmodule

// File: tb/tb_fp_cmp_unit.sv
// Bench for fp_cmp_unit: directed vectors, back-pressure burst, mid-flight
// reset and a randomized run scored against a real-number reference model.
module tb_fp_cmp_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, result, nv;
  logic [31:0] fp_a, fp_b;
  logic [1:0]  op;
  logic [15:0] nv_count;

  fp_cmp_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fp_a(fp_a), .fp_b(fp_b), .op(op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .nv(nv), .nv_count(nv_count)
  );

  always #5 clk = ~clk;

  int         ncmp = 0, nfail = 0;
  logic [1:0] q[$];
  logic [1:0] cur_exp, hold_val;
  logic       acc, hold_vld;
  logic [15:0] mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value of a non-NaN binary32 as a real; infinities as huge magnitudes.
  function automatic real f2r(input logic [31:0] x);
    int  e;
    real m;
    e = int'(x[30:23]);
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = real'(x[22:0]) * (2.0 ** -149.0);
    else             m = real'(int'(x[22:0]) + 8388608) * (2.0 ** real'(e - 150));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit  an, bn, as_, bs_;
    real ra, rb;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    as_ = an && !a[22];
    bs_ = bn && !b[22];
    if (o == 2'b11) return 2'b00;
    if (an || bn)   return {1'b0, (o == 2'b10) ? (as_ || bs_) : 1'b1};
    ra = f2r(a);
    rb = f2r(b);
    case (o)
      2'b00:   return {ra <= rb, 1'b0};
      2'b01:   return {ra <  rb, 1'b0};
      default: return {ra == rb, 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd(input logic [31:0] other);
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 7))
      0: v = {v[31], 31'd0};
      1: v = {v[31], 8'hFF, 23'd0};
      2: v = {v[31], 8'hFF, 1'b1, v[21:0]};
      3: v = {v[31], 8'hFF, 1'b0, v[21:1], 1'b1};
      4: v = {v[31], 8'h00, v[22:0]};
      5: v = {v[31], 8'h7F + 8'(v[2:0]), 20'd0, v[5:3]};
      6: ;
      default: v = other;
    endcase
    return v;
  endfunction

  // One clock: sample handshakes mid-cycle, score, advance to the next negedge.
  task automatic tick();
    bit in_rst, dlv;
    #1;
    in_rst = !rst_n;
    acc    = in_valid && in_ready;
    dlv    = out_valid && out_ready;
    if (!in_rst) begin
      if (hold_vld) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", {result, nv}, hold_val);
      end
      if (dlv) begin
        chk("deliver_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          cur_exp = cur_exp;
          chk("result_nv", {result, nv}, q[0]);
          if (q[0][0] && mcnt != 16'hFFFF) mcnt++;
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back(ref_cmp(op, fp_a, fp_b));
      hold_vld = out_valid && !out_ready;
      hold_val = {result, nv};
    end
    @(posedge clk);
    @(negedge clk);
    if (in_rst) begin
      q.delete();
      mcnt     = 0;
      hold_vld = 0;
    end else begin
      chk("nv_count", nv_count, mcnt);
    end
  endtask

  // Issue one request and wait (bounded) for acceptance; checks the fixed expectation too.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [1:0] exp);
    int n;
    op = o; fp_a = a; fp_b = b; in_valid = 1'b1;
    chk("model_vs_table", ref_cmp(o, a, b), exp);
    n = 0;
    do begin tick(); n++; end while (!acc && n < 50);
    chk("accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin tick(); n++; end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int  sent, cyc;
    bit  saw_drop;
    logic [31:0] a, b;
    logic [31:0] burst_a[4], burst_b[4];
    logic [1:0]  burst_op[4];

    rst_n = 0; in_valid = 0; out_ready = 1; op = 0; fp_a = 0; fp_b = 0;
    mcnt = 0; hold_vld = 0; cur_exp = 0; hold_val = 0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_result", result, 1'b0);
    chk("rst_nv", nv, 1'b0);
    chk("rst_nv_count", nv_count, 16'd0);
    rst_n = 1;
    #1 chk("ready_after_rst", in_ready, 1'b1);

    // Latency: accepted at edge 1, visible after edge 2.
    op = 2'b10; fp_a = 32'h3F800000; fp_b = 32'h3F800000; in_valid = 1;
    tick();
    chk("lat_accept", acc, 1'b1);
    in_valid = 0;
    chk("lat_cycle1", out_valid, 1'b0);
    tick();
    chk("lat_cycle2", out_valid, 1'b1);
    chk("lat_result", {result, nv}, 2'b10);
    drain();

    send(2'b10, 32'h00000000, 32'h80000000, 2'b10);
    send(2'b01, 32'h00000000, 32'h80000000, 2'b00);
    send(2'b00, 32'h00000000, 32'h80000000, 2'b10);
    send(2'b10, 32'h7FC00000, 32'h3F800000, 2'b00);
    send(2'b10, 32'h7FA00000, 32'h3F800000, 2'b01);
    send(2'b01, 32'h7FC00000, 32'h3F800000, 2'b01);
    drain();
    chk("nv_count_two", nv_count, 16'd2);
    send(2'b01, 32'hC2480000, 32'h42480000, 2'b10);
    send(2'b01, 32'h00000001, 32'h00000002, 2'b10);
    send(2'b00, 32'hFF800000, 32'h7F800000, 2'b10);
    send(2'b01, 32'h7F800000, 32'h7F800000, 2'b00);
    send(2'b11, 32'h3F800000, 32'h40000000, 2'b00);
    send(2'b00, 32'hBF800000, 32'hC0000000, 2'b00);
    drain();

    // Back-to-back burst with consumer stalled on cycles 3-5.
    burst_op = '{2'b01, 2'b01, 2'b10, 2'b00};
    burst_a  = '{32'h3F800000, 32'h40000000, 32'h7F800001, 32'h3F800000};
    burst_b  = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    sent = 0; saw_drop = 0;
    for (cyc = 1; cyc <= 40 && (sent < 4 || q.size() != 0 || out_valid); cyc++) begin
      in_valid  = (sent < 4);
      op        = burst_op[sent % 4];
      fp_a      = burst_a[sent % 4];
      fp_b      = burst_b[sent % 4];
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1 if (!in_ready) saw_drop = 1;
      #0 tick();
      if (acc) sent++;
    end
    in_valid = 0;
    chk("burst_sent", sent, 4);
    chk("burst_ready_drop", saw_drop, 1'b1);
    drain();

    // Randomized traffic with random stalls on both sides.
    for (int i = 0; i < 400; i++) begin
      a         = rnd_opnd(32'h0);
      b         = rnd_opnd(a);
      op        = 2'($urandom);
      fp_a      = a;
      fp_b      = b;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with two requests in flight.
    out_ready = 0;
    send(2'b10, 32'h7FA00000, 32'h0, 2'b01);
    send(2'b01, 32'h3F800000, 32'h40000000, 2'b10);
    rst_n = 0;
    tick();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_nv_count", nv_count, 16'd0);
    chk("midrst_in_ready", in_ready, 1'b0);
    rst_n = 1; out_ready = 1;
    #1 chk("midrst_ready_after", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_stale", out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/fp_cmp_unit.md
FP_CMP_UNIT -- requirements
Module: fp_cmp_unit

Interface
REQ-001 The module SHALL have no parameters; operand width is fixed at 32 bits (IEEE-754 binary32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request carries valid operands/op this cycle.
REQ-005 in_ready  output  1  unit accepts a request this cycle.
REQ-006 fp_a  input  32  operand A.
REQ-007 fp_b  input  32  operand B.
REQ-008 op  input  2  2'b00 FLE, 2'b01 FLT, 2'b10 FEQ, 2'b11 reserved.
REQ-009 out_valid  output  1  result/flag valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  1  comparison outcome (1 = true).
REQ-012 nv  output  1  invalid-operation flag for this result.
REQ-013 nv_count  output  16  saturating count of delivered results with nv=1.

Function
REQ-014 Request accepted when in_valid && in_ready on a rising edge; result delivered when out_valid && out_ready on a rising edge.
REQ-015 Two-stage pipeline: S1 registers operands, op and class bits (zero, inf, qNaN, sNaN, sign); S2 registers result and nv.
REQ-016 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no back-pressure; throughput one request per cycle.
REQ-017 Each stage SHALL advance when empty or when the next stage advances; S2 advances when out_ready=1 or S2 empty.
REQ-018 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; no request SHALL be dropped or duplicated.
REQ-019 While out_valid=1 and out_ready=0, result and nv SHALL hold stable.
REQ-020 NaN: exponent 8'hFF, mantissa nonzero; sNaN when mantissa bit 22 = 0, qNaN otherwise.
REQ-021 Any NaN operand: result=0 for FLE, FLT, FEQ.
REQ-022 FEQ: nv=1 only if either operand is sNaN.
REQ-023 FLT/FLE: nv=1 if either operand is any NaN.
REQ-024 +0 and -0 SHALL compare equal (FEQ=1, FLE=1, FLT=0 either order).
REQ-025 Subnormals SHALL be compared exactly, no flush-to-zero; infinities order as extremes of same-signed values.
REQ-026 Non-NaN ordering: sign-magnitude compare; both negative reverses magnitude order.
REQ-027 op=2'b11: result=0, nv=0, still consumes one pipeline slot.
REQ-028 nv_count SHALL increment by 1 on each delivery with nv=1, saturating at 16'hFFFF.

Reset
REQ-029 While rst_n=0 at a rising edge: S1/S2 empty, out_valid=0, result=0, nv=0, nv_count=0.
REQ-030 in_ready SHALL be 0 during a cycle where rst_n=0, and 1 on the first cycle after reset release.
REQ-031 Reset mid-operation SHALL discard all in-flight requests; none SHALL appear after release.

Verification
REQ-032 FEQ 3F800000 vs 3F800000, out_ready=1 -> 2 cycles later out_valid=1, result=1, nv=0.
REQ-033 FEQ 00000000 vs 80000000 -> result=1; FLT same pair -> result=0; FLE -> result=1; nv=0 all.
REQ-034 FEQ 7FC00000 vs 3F800000 -> result=0, nv=0; FEQ 7FA00000 vs 3F800000 -> result=0, nv=1; FLT 7FC00000 vs 3F800000 -> result=0, nv=1; nv_count=2.
REQ-035 FLT C2480000 vs 42480000 -> 1; FLT 00000001 vs 00000002 -> 1; FLE FF800000 vs 7F800000 -> 1; FLT 7F800000 vs 7F800000 -> 0.
REQ-036 Back-to-back 4 requests, out_ready=0 for cycles 3-5 -> in_ready drops once S1 and S2 full, held result stable, all 4 results delivered in order, none lost.
REQ-037 Reset asserted with 2 requests in flight -> out_valid=0 next cycle, nv_count=0, no stale result after release.
